// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encoding, the FSM state encoding and small op-decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // MULT and DIV treat their operands as two's complement.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div.sv
// Iterative HI/LO multiply/divide unit, one bit per cycle.
// Multiply is shift-add, divide is restoring; both run on magnitudes in one
// shared 2*WIDTH partial-result/shift register and fix signs on the last step.
// Ports:
//   clock, reset (async, active-low)
//   start, op, rs_val, rt_val : request and operands, sampled on the rising edge
//   busy      : high while iterating
//   done      : one-cycle completion pulse
//   hi, lo    : result registers (remainder/quotient for divide)
//   div_zero  : sticky divide-by-zero flag
// Build option: define MULT_DIV_DIVIDE_EN to compile in the divide datapath;
// without it DIV/DIVU complete after one cycle with hi/lo unchanged.
module mult_div
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_rs_q, neg_rs_d;
    logic             neg_rt_q, neg_rt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] mul_next;
    logic [ACC_W-1:0] prod;
    logic             div_skip;
`ifdef MULT_DIV_DIVIDE_EN
    logic             dz_q, dz_d;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [ACC_W-1:0] div_next;
    logic [WIDTH-1:0] quo, rem;
`endif

    // Next-state, datapath step and result write-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_rs_d = neg_rs_q;
        neg_rt_d = neg_rt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULT_DIV_DIVIDE_EN
        dz_d     = dz_q;
`endif

        rs_neg = op_is_signed(op) & rs_val[WIDTH-1];
        rt_neg = op_is_signed(op) & rt_val[WIDTH-1];
        rs_mag = rs_neg ? -rs_val : rs_val;
        rt_mag = rt_neg ? -rt_val : rt_val;

        // Shift-add: conditionally add into the upper half, then shift right.
        mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        prod     = (neg_rs_q ^ neg_rt_q) ? -mul_next : mul_next;

`ifdef MULT_DIV_DIVIDE_EN
        // Restoring step: shift one dividend bit into the remainder and try
        // subtracting; the quotient bit enters at the bottom of the register.
        div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
        quo       = (neg_rs_q ^ neg_rt_q) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        rem       = neg_rs_q ? -div_next[ACC_W-1:WIDTH] : div_next[ACC_W-1:WIDTH];
        div_skip  = is_div_q && (opnd_q == '0);
`else
        div_skip  = is_div_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = op_is_div(op);
                    neg_rs_d = rs_neg;
                    neg_rt_d = rt_neg;
                    acc_d    = {{WIDTH{1'b0}}, rt_mag};
                    opnd_d   = rs_mag;
`ifdef MULT_DIV_DIVIDE_EN
                    dz_d     = 1'b0;
                    if (op_is_div(op)) begin
                        acc_d  = {{WIDTH{1'b0}}, rs_mag};
                        opnd_d = rt_mag;
                    end
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (div_skip) begin
                    // Zero divisor (or no divider built): finish with hi/lo untouched.
                    state_d = DONE;
`ifdef MULT_DIV_DIVIDE_EN
                    dz_d    = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
`ifdef MULT_DIV_DIVIDE_EN
                    acc_d = is_div_q ? div_next : mul_next;
`else
                    acc_d = mul_next;
`endif
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        hi_d    = prod[ACC_W-1:WIDTH];
                        lo_d    = prod[WIDTH-1:0];
`ifdef MULT_DIV_DIVIDE_EN
                        if (is_div_q) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_rs_q <= 1'b0;
            neg_rt_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULT_DIV_DIVIDE_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_rs_q <= neg_rs_d;
            neg_rt_q <= neg_rt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULT_DIV_DIVIDE_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULT_DIV_DIVIDE_EN
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule
